aes_key_expand_param: RTL and testbench

Parametrised, iterative AES key-schedule engine covering AES-128/192/256 through KEY_BITS. It computes one 32-bit schedule word per clock using four S-box lookups, and holds the full expanded schedule on a flat bus for the iterative cipher datapath. It also streams each completed 128-bit round key with a valid pulse, so a pipelined cipher can start before expansion finishes.

---
 rtl/aes_key_expand_param.sv | 160 ++++++++++++++++
 tb/tb_aes_key_expand_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_param.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_param
// Brief    : Iterative AES-128/192/256 key schedule, one word per clock,
//            with in-order streaming of completed 128-bit round keys.
// Revision : 1.0
// ============================================================================
module aes_key_expand_param #(
    parameter int KEY_BITS = 128
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [KEY_BITS-1:0]             key,
    output logic                            busy,
    output logic                            done,
    output logic [128*(KEY_BITS/32+7)-1:0]  exp_key,
    output logic                            rk_valid,
    output logic [3:0]                      rk_index,
    output logic [127:0]                    rk_data
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand_param: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] y;
        for (int b = 0; b < 4; b++) begin
            y[8*b +: 8] = c_SBOX[2047 - 8*int'(x[8*b +: 8]) -: 8];
        end
        return y;
    endfunction

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

    state_t       r_state;
    logic [31:0]  r_w [NW];
    logic [5:0]   r_i;
    logic [2:0]   r_mod;
    logic [7:0]   r_rcon;
    logic [3:0]   r_rk_next;

    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_temp;
    logic [31:0]  w_new;
    logic [7:0]   w_xtime;
    logic         w_rk_ready;
    logic [127:0] w_rk_slice;

    assign w_prev  = r_w[r_i - 6'd1];
    assign w_back  = r_w[r_i - 6'(NK)];
    assign w_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_new   = w_back ^ w_temp;

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0) begin
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
        end else if (NK == 8 && r_mod == 3'd4) begin
            w_temp = sub_word(w_prev);
        end
    end

    // The word written on this edge is forwarded so the key completing now
    // is emitted in the same cycle its last word becomes visible.
    always_comb begin
        w_rk_ready = (r_rk_next <= 4'(NR)) && ({r_rk_next, 2'b11} <= r_i);
        w_rk_slice = '0;
        for (int m = 0; m < 4; m++) begin
            if ({r_rk_next, 2'(m)} == r_i) begin
                w_rk_slice[127 - 32*m -: 32] = w_new;
            end else begin
                w_rk_slice[127 - 32*m -: 32] = r_w[{r_rk_next, 2'(m)}];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_mod     <= '0;
            r_rcon    <= 8'h01;
            r_rk_next <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_index  <= '0;
            rk_data   <= '0;
            for (int k = 0; k < NW; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            done     <= 1'b0;
            rk_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            r_w[k] <= key[KEY_BITS-1-32*k -: 32];
                        end
                        r_i       <= 6'(NK);
                        r_mod     <= '0;
                        r_rcon    <= 8'h01;
                        r_rk_next <= 4'd1;
                        busy      <= 1'b1;
                        rk_valid  <= 1'b1;
                        rk_index  <= '0;
                        rk_data   <= key[KEY_BITS-1 -: 128];
                        r_state   <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    r_w[r_i] <= w_new;
                    if (r_mod == 3'd0) begin
                        r_rcon <= w_xtime;
                    end
                    r_mod <= (r_mod == 3'(NK-1)) ? 3'd0 : r_mod + 3'd1;
                    if (w_rk_ready) begin
                        rk_valid  <= 1'b1;
                        rk_index  <= r_rk_next;
                        rk_data   <= w_rk_slice;
                        r_rk_next <= r_rk_next + 4'd1;
                    end
                    if (r_i == 6'(NW-1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_i <= r_i + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NW; k++) begin : g_exp_key
        assign exp_key[128*(k/4) + 32*(3-k%4) +: 32] = r_w[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand_param
// Brief    : Directed FIPS-197 vectors for the 128/192/256 key schedules.
// Revision : 1.0
// ============================================================================
module tb_aes_key_expand_param;

    localparam logic [127:0] c_K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_K1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_K1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_K2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_K2_R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] c_K2_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] c_K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] c_K192_R1 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] c_K192_R12= 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] c_K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_K256_R0 = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] c_K256_R1 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_K256_R14= 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start [3];
    logic          busy  [3];
    logic          done  [3];
    logic          rkv   [3];
    logic [3:0]    rki   [3];
    logic [127:0]  rkd   [3];
    logic [127:0]  key128;
    logic [191:0]  key192;
    logic [255:0]  key256;
    logic [1407:0] ek128;
    logic [1663:0] ek192;
    logic [1919:0] ek256;

    aes_key_expand_param #(.KEY_BITS(128)) u_dut128 (
        .clock(clk), .reset(rst_n), .start(start[0]), .key(key128),
        .busy(busy[0]), .done(done[0]), .exp_key(ek128),
        .rk_valid(rkv[0]), .rk_index(rki[0]), .rk_data(rkd[0])
    );
    aes_key_expand_param #(.KEY_BITS(192)) u_dut192 (
        .clock(clk), .reset(rst_n), .start(start[1]), .key(key192),
        .busy(busy[1]), .done(done[1]), .exp_key(ek192),
        .rk_valid(rkv[1]), .rk_index(rki[1]), .rk_data(rkd[1])
    );
    aes_key_expand_param #(.KEY_BITS(256)) u_dut256 (
        .clock(clk), .reset(rst_n), .start(start[2]), .key(key256),
        .busy(busy[2]), .done(done[2]), .exp_key(ek256),
        .rk_valid(rkv[2]), .rk_index(rki[2]), .rk_data(rkd[2])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-key stream log per instance: count, ordering, last data/cycle per index.
    int           rk_cnt    [3];
    int           order_bad [3];
    int           nxt       [3];
    int           dcnt      [3];
    int           dlast     [3];
    int           dprev     [3];
    logic [127:0] seen      [3][16];
    int           scyc      [3][16];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                nxt[d] = 0;
            end else begin
                if (rkv[d]) begin
                    if (int'(rki[d]) != nxt[d]) order_bad[d]++;
                    nxt[d] = (int'(rki[d]) == 10 + 2*d) ? 0 : int'(rki[d]) + 1;
                    seen[d][rki[d]] = rkd[d];
                    scyc[d][rki[d]] = cyc;
                    rk_cnt[d]++;
                end
                if (done[d]) begin
                    dprev[d] = dlast[d];
                    dlast[d] = cyc;
                    dcnt[d]++;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse_start(input int d, output int acc);
        @(negedge clk);
        start[d] = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target);
        int n = 0;
        while (dcnt[d] < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 128'(dcnt[d]), 128'(target));
        repeat (3) @(negedge clk);
    endtask

    int acc, acc2, b_rk, b_d, b_ob;

    initial begin
        rst_n  = 1'b0;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        key128 = c_K1;
        key192 = c_K192;
        key256 = c_K256;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",  128'(busy[0]), 128'd0);
        check("rst_done",  128'(done[0]), 128'd0);
        check("rst_rkv",   128'(rkv[0]), 128'd0);
        check("rst_rki",   128'(rki[0]), 128'd0);
        check("rst_rkd",   rkd[0], 128'd0);
        check("rst_exp0",  ek128[127:0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: AES-128 FIPS-197 A.1 key
        b_rk = rk_cnt[0]; b_d = dcnt[0]; b_ob = order_bad[0];
        pulse_start(0, acc);
        check("s1_busy_mid", 128'(busy[0]), 128'd1);
        wait_done(0, b_d + 1);
        check("s1_latency",  128'(dlast[0] - acc), 128'd40);
        check("s1_done_cnt", 128'(dcnt[0] - b_d), 128'd1);
        check("s1_rk_cnt",   128'(rk_cnt[0] - b_rk), 128'd11);
        check("s1_order",    128'(order_bad[0] - b_ob), 128'd0);
        check("s1_rk0_cyc",  128'(scyc[0][0] - acc), 128'd0);
        check("s1_rk10_cyc", 128'(scyc[0][10] - acc), 128'd40);
        check("s1_rk10",     seen[0][10], c_K1_R10);
        check("s1_exp10",    ek128[1407:1280], c_K1_R10);
        check("s1_exp1",     ek128[255:128], c_K1_R1);
        check("s1_exp0",     ek128[127:0], c_K1);
        check("s1_busy_end", 128'(busy[0]), 128'd0);

        // 2: AES-128 FIPS-197 C.1 key
        key128 = c_K2;
        b_d = dcnt[0];
        pulse_start(0, acc);
        wait_done(0, b_d + 1);
        check("s2_rk10",  seen[0][10], c_K2_R10);
        check("s2_rk1",   seen[0][1], c_K2_R1);
        check("s2_exp10", ek128[1407:1280], c_K2_R10);

        // 3: AES-192
        b_rk = rk_cnt[1]; b_d = dcnt[1]; b_ob = order_bad[1];
        pulse_start(1, acc);
        wait_done(1, b_d + 1);
        check("s3_latency", 128'(dlast[1] - acc), 128'd46);
        check("s3_rk_cnt",  128'(rk_cnt[1] - b_rk), 128'd13);
        check("s3_order",   128'(order_bad[1] - b_ob), 128'd0);
        check("s3_rk1",     seen[1][1], c_K192_R1);
        check("s3_rk12",    seen[1][12], c_K192_R12);
        check("s3_exp12",   ek192[1663:1536], c_K192_R12);
        check("s3_rk12_cyc", 128'(scyc[1][12] - acc), 128'd46);

        // 4: AES-256
        b_rk = rk_cnt[2]; b_d = dcnt[2]; b_ob = order_bad[2];
        pulse_start(2, acc);
        wait_done(2, b_d + 1);
        check("s4_latency", 128'(dlast[2] - acc), 128'd52);
        check("s4_rk_cnt",  128'(rk_cnt[2] - b_rk), 128'd15);
        check("s4_order",   128'(order_bad[2] - b_ob), 128'd0);
        check("s4_rk0_cyc", 128'(scyc[2][0] - acc), 128'd0);
        check("s4_rk1_cyc", 128'(scyc[2][1] - acc), 128'd1);
        check("s4_rk0",     seen[2][0], c_K256_R0);
        check("s4_rk1",     seen[2][1], c_K256_R1);
        check("s4_rk14",    seen[2][14], c_K256_R14);
        check("s4_exp14",   ek256[1919:1792], c_K256_R14);

        // 5: start pulses while busy (with a different key), then start held through done
        key128 = c_K1;
        b_rk = rk_cnt[0]; b_d = dcnt[0]; b_ob = order_bad[0];
        pulse_start(0, acc);
        key128 = c_K2;
        for (int p = 0; p < 3; p++) begin
            repeat (6) @(negedge clk);
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
        end
        key128 = c_K1;
        while (cyc < acc + 35) @(negedge clk);
        start[0] = 1'b1;
        while (cyc < acc + 41) @(negedge clk);
        start[0] = 1'b0;
        acc2 = acc + 41;
        wait_done(0, b_d + 2);
        check("s5_first_lat",  128'(dprev[0] - acc), 128'd40);
        check("s5_second_lat", 128'(dlast[0] - acc2), 128'd40);
        check("s5_done_cnt",   128'(dcnt[0] - b_d), 128'd2);
        check("s5_rk_cnt",     128'(rk_cnt[0] - b_rk), 128'd22);
        check("s5_order",      128'(order_bad[0] - b_ob), 128'd0);
        check("s5_rk0_cyc",    128'(scyc[0][0] - acc2), 128'd0);
        check("s5_rk10",       seen[0][10], c_K1_R10);
        check("s5_exp10",      ek128[1407:1280], c_K1_R10);
        check("s5_exp1",       ek128[255:128], c_K1_R1);

        // 6: asynchronous reset mid-expansion, then a fresh start
        pulse_start(0, acc);
        while (cyc < acc + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_busy",  128'(busy[0]), 128'd0);
        check("s6_done",  128'(done[0]), 128'd0);
        check("s6_rkv",   128'(rkv[0]), 128'd0);
        check("s6_rkd",   rkd[0], 128'd0);
        check("s6_exp0",  ek128[127:0], 128'd0);
        check("s6_exp1",  ek128[255:128], 128'd0);
        b_rk = rk_cnt[0]; b_d = dcnt[0]; b_ob = order_bad[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("s6_no_rk",   128'(rk_cnt[0] - b_rk), 128'd0);
        check("s6_no_done", 128'(dcnt[0] - b_d), 128'd0);
        pulse_start(0, acc);
        wait_done(0, b_d + 1);
        check("s6_latency", 128'(dlast[0] - acc), 128'd40);
        check("s6_rk_cnt",  128'(rk_cnt[0] - b_rk), 128'd11);
        check("s6_order",   128'(order_bad[0] - b_ob), 128'd0);
        check("s6_rk10",    seen[0][10], c_K1_R10);
        check("s6_exp10",   ek128[1407:1280], c_K1_R10);
        check("s6_exp0",    ek128[127:0], c_K1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
